dl_skid_buffer: RTL

DL_SKID_BUFFER -- requirements
Module: dl_skid_buffer

---
 rtl/dl_skid_buffer.sv | 85 ++++++++
 1 files changed

// File: rtl/dl_skid_buffer.sv
// dl_skid_buffer: two-entry valid/ready skid buffer. The ready signal to the
// producer comes from a flop only, which breaks the timing path between
// downstream ready and upstream ready.
// Ports:
//   clk, rst            - clock and synchronous active-high reset
//   in_valid/in_data    - upstream offer
//   in_ready            - buffer can take in_data this cycle (skid empty, not in reset)
//   out_valid/out_data  - downstream payload, driven straight from the main register
//   out_ready           - downstream takes out_data this cycle
//   occupancy           - number of held entries (0..2)
module dl_skid_buffer #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  input  logic             out_ready,
  output logic [1:0]       occupancy
);

  logic             main_valid_q, main_valid_d;
  logic [WIDTH-1:0] main_data_q,  main_data_d;
  logic             skid_valid_q, skid_valid_d;
  logic [WIDTH-1:0] skid_data_q,  skid_data_d;

  logic accept;
  logic consume;

  // Handshake terms; in_ready depends only on rst and a flop.
  assign in_ready  = ~rst & ~skid_valid_q;
  assign accept    = in_valid & in_ready;
  assign consume   = main_valid_q & out_ready;

  assign out_valid = main_valid_q;
  assign out_data  = main_data_q;
  assign occupancy = {1'b0, main_valid_q} + {1'b0, skid_valid_q};

  // Next-state: main always holds the oldest entry, skid the younger one.
  always_comb begin
    main_valid_d = main_valid_q;
    main_data_d  = main_data_q;
    skid_valid_d = skid_valid_q;
    skid_data_d  = skid_data_q;

    if (!main_valid_q) begin
      if (accept) begin
        main_valid_d = 1'b1;
        main_data_d  = in_data;
      end
    end else if (consume) begin
      if (skid_valid_q) begin
        // in_ready is low here, so no accept can race with the refill
        main_data_d  = skid_data_q;
        skid_valid_d = 1'b0;
      end else if (accept) begin
        main_data_d  = in_data;
      end else begin
        main_valid_d = 1'b0;
      end
    end else if (accept) begin
      skid_valid_d = 1'b1;
      skid_data_d  = in_data;
    end
  end

  // State registers with synchronous reset; reset drops every held entry.
  always_ff @(posedge clk) begin
    if (rst) begin
      main_valid_q <= 1'b0;
      main_data_q  <= '0;
      skid_valid_q <= 1'b0;
      skid_data_q  <= '0;
    end else begin
      main_valid_q <= main_valid_d;
      main_data_q  <= main_data_d;
      skid_valid_q <= skid_valid_d;
      skid_data_q  <= skid_data_d;
    end
  end

endmodule
